avalon_bus_ram: RTL and testbench

Avalon-MM slave word memory responding to the CPU's bus controller (`address/read/write/waitrequest/writedata/byteenable/readdata`). Decodes a fixed address window, inserts programmable wait states through `waitrequest`, applies byte-lane writes and returns registered read data that stays stable after the transfer. It is the bench-side instruction/data RAM for CPU tests and the memory model used in integration.

---
 rtl/avalon_bus_ram_pkg.sv | 7 +
 rtl/avalon_bus_ram_if.sv | 14 +
 rtl/avalon_bus_ram_lfsr16.sv | 15 +
 rtl/avalon_bus_ram.sv | 60 ++++++
 tb/tb_avalon_bus_ram.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/avalon_bus_ram_pkg.sv
// bus_pkg: shared slave state enum, reset-vector base address and bus width constants
package bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} slv_state_e;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int BE_W = 4;
  localparam int DATA_W = 8 * BE_W;
endpackage

// File: rtl/avalon_bus_ram_if.sv
// avalon_bus_ram_if: Avalon-MM address/read/write/writedata/byteenable/waitrequest/readdata/err bundle with master and slave modports
interface avalon_bus_ram_if;
  import bus_pkg::*;
  logic [31:0] address;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0] byteenable;
  logic waitrequest;
  logic [DATA_W-1:0] readdata;
  logic err;
  modport master(output address, read, write, writedata, byteenable, input waitrequest, readdata, err);
  modport slave(input address, read, write, writedata, byteenable, output waitrequest, readdata, err);
endinterface

// File: rtl/avalon_bus_ram_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping when en is high, loads seed on async active-low reset
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);
  logic [15:0] state_q, state_d;
  always_comb state_d = en ? {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]} : state_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= seed;
    else state_q <= state_d;
  assign state = state_q;
endmodule

// File: rtl/avalon_bus_ram.sv
// avalon_bus_ram: Avalon-MM word RAM with address window, wait states, byte lanes, err pulse; AVALON_BUS_RAM_RANDOM_WAIT_EN adds LFSR extra waits
module avalon_bus_ram
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input logic              clk,
  input logic              reset,
  avalon_bus_ram_if.slave  bus
);
  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];
  slv_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, wcnt;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] off, widx;
  logic [ADDR_WIDTH-1:0] idx;
  logic req, ok, fin;
`ifdef AVALON_BUS_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  lfsr16 u_lfsr (.clk(clk), .reset(reset), .en(state_q == DONE), .seed(16'hACE1), .state(lfsr));
  assign wcnt = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
  assign wcnt = 5'(WAIT_CYCLES);
`endif
  assign req = bus.read | bus.write;
  assign off = bus.address - BASE_ADDR;
  assign widx = off >> 2;
  assign idx = widx[ADDR_WIDTH-1:0];
  assign ok = widx[31:ADDR_WIDTH] == '0 && bus.address[1:0] == 2'b00;
  always_comb begin
    fin = req && (state_q == IDLE ? wcnt == 5'd1 : state_q == WAIT && cnt_q == 5'd1);
    state_d = !req || state_q == DONE ? IDLE : fin ? DONE : WAIT;
    cnt_d = state_d != WAIT ? 5'd0 : state_q == IDLE ? wcnt - 5'd1 : cnt_q - 5'd1;
    rdata_d = fin && bus.read ? (ok ? mem[idx] : '0) : rdata_q;
    err_d = fin && (!ok || (bus.read && bus.write));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  always_ff @(posedge clk)
    if (state_q == DONE && bus.write && !bus.read && ok)
      for (int i = 0; i < BE_W; i++)
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
  assign bus.waitrequest = req && state_q != DONE;
  assign bus.readdata = rdata_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_avalon_bus_ram.sv
// tb_avalon_bus_ram: vector table, hand sequences and randomized model check of avalon_bus_ram (W=1 and W=3 instances)
module tb_avalon_bus_ram;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic [31:0] exp_rd;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst3 = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  avalon_bus_ram_if b0();
  avalon_bus_ram_if b3();
  avalon_bus_ram #(.WAIT_CYCLES(1)) u0 (.clk(clk), .reset(rst0), .bus(b0));
  avalon_bus_ram #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));
  always #5 clk = ~clk;
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction
  function automatic void chk_waits(string name, int got, int w);
    n_chk++;
`ifdef AVALON_BUS_RAM_RANDOM_WAIT_EN
    if (got >= w && got <= w + 3) n_pass++;
    else $display("FAIL %s: got %0d waits expected %0d..%0d", name, got, w, w + 3);
`else
    if (got == w) n_pass++;
    else $display("FAIL %s: got %0d waits expected %0d", name, got, w);
`endif
  endfunction
  function automatic vec_t v(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be, logic [31:0] er, logic ee);
    vec_t t;
    t.rd = rd; t.wr = wr; t.a = a; t.wd = wd; t.be = be; t.exp_rd = er; t.exp_err = ee;
    return t;
  endfunction
  function automatic bit in_win(logic [31:0] a);
    return a >= BASE && a < BASE + 32'h1000 && a % 4 == 0;
  endfunction
  task automatic drive(input bit s, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (s) begin
      b3.read = rd; b3.write = wr; b3.address = a; b3.writedata = wd; b3.byteenable = be;
    end else begin
      b0.read = rd; b0.write = wr; b0.address = a; b0.writedata = wd; b0.byteenable = be;
    end
  endtask
  // called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
  task automatic xfer(input bit s, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rdat, output int waits, output int errs);
    bit done = 0;
    drive(s, rd, wr, a, wd, be);
    waits = 0; errs = 0; rdat = 'x;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      errs += int'(s ? b3.err : b0.err);
      if (s ? b3.waitrequest : b0.waitrequest) waits++;
      else begin
        done = 1;
        rdat = s ? b3.readdata : b0.readdata;
      end
      @(posedge clk); #1;
    end
    drive(s, 0, 0, 32'h0, 32'h0, 4'h0);
    if (!done) begin
      n_chk++;
      $display("FAIL timeout: waitrequest never dropped for address %h", a);
    end
  endtask
  vec_t tbl[19];
  logic [31:0] mm[16];
  logic [31:0] rdat, last_rd, a, wd, exp;
  logic [3:0] be, seen;
  logic rd, wr;
  int waits, errs, k, kind;
  time t0;
  initial begin
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_waitreq", {31'b0, b0.waitrequest}, 0);
    check("rst_readdata", b0.readdata, 0);
    check("rst_err", {31'b0, b0.err}, 0);
    rst0 = 1; rst3 = 1;
    @(posedge clk); #1;
    check("post_rst_readdata", b0.readdata, 0);
    xfer(0, 0, 1, BASE, 32'h2402_0005, 4'hF, rdat, waits, errs);
    xfer(0, 1, 0, BASE, 32'h0, 4'h0, rdat, waits, errs);
    chk_waits("boot_read_waits", waits, 1);
    check("boot_read_data", rdat, 32'h2402_0005);
    for (int i = 0; i < 5; i++) begin
      #4;
      check($sformatf("boot_hold%0d", i), b0.readdata, 32'h2402_0005);
      @(posedge clk); #1;
    end
    tbl[0]  = v(0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h2402_0005, 0);
    tbl[1]  = v(0, 1, BASE + 32'h10, 32'h0000_0011, 4'h1, 32'h2402_0005, 0);
    tbl[2]  = v(1, 0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BE11, 0);
    tbl[3]  = v(1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1);
    tbl[4]  = v(1, 0, BASE + 32'h2, 32'h0, 4'h0, 32'h0, 1);
    tbl[5]  = v(0, 1, BASE + 32'h1000, 32'h5555_5555, 4'hF, 32'h0, 1);
    tbl[6]  = v(1, 0, BASE, 32'h0, 4'h0, 32'h2402_0005, 0);
    tbl[7]  = v(1, 1, BASE + 32'h10, 32'h0000_0001, 4'hF, 32'hDEAD_BE11, 1);
    tbl[8]  = v(1, 0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BE11, 0);
    tbl[9]  = v(0, 1, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BE11, 0);
    tbl[10] = v(1, 0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BE11, 0);
    tbl[11] = v(0, 1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BE11, 0);
    tbl[12] = v(0, 1, BASE + 32'h14, 32'h0, 4'h6, 32'hDEAD_BE11, 0);
    tbl[13] = v(1, 0, BASE + 32'h14, 32'h0, 4'h0, 32'hFF00_00FF, 0);
    tbl[14] = v(0, 1, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'hFF00_00FF, 0);
    tbl[15] = v(1, 0, BASE + 32'hFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
    tbl[16] = v(0, 1, BASE - 32'h4, 32'h1111_2222, 4'hF, 32'hCAFE_F00D, 1);
    tbl[17] = v(1, 0, BASE + 32'hFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
    tbl[18] = v(1, 0, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1);
    foreach (tbl[i]) begin
      xfer(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be, rdat, waits, errs);
      chk_waits($sformatf("vec%0d_waits", i), waits, 1);
      check($sformatf("vec%0d_readdata", i), rdat, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), errs, {31'b0, tbl[i].exp_err});
    end
    #4;
    check("err_one_cycle", {31'b0, b0.err}, 0);
    @(posedge clk); #1;
    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      xfer(0, 0, 1, BASE + 32'(4 * i), mm[i], 4'hF, rdat, waits, errs);
    end
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 15);
      kind = $urandom_range(0, 4);
      rd = kind <= 1 || kind == 4;
      wr = kind >= 2;
      wd = $urandom;
      be = 4'($urandom);
      case ($urandom_range(0, 9))
        0: a = BASE + 32'h1000 + 32'(4 * k);
        1: a = BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
        2: a = BASE - 32'(4 * (k + 1));
        default: a = BASE + 32'(4 * k);
      endcase
      if (rd) last_rd = in_win(a) ? mm[(a - BASE) / 4] : 32'h0;
      else if (in_win(a))
        for (int b = 0; b < 4; b++) if (be[b]) mm[(a - BASE) / 4][8*b +: 8] = wd[8*b +: 8];
      xfer(0, rd, wr, a, wd, be, rdat, waits, errs);
      chk_waits($sformatf("rnd%0d_waits", n), waits, 1);
      check($sformatf("rnd%0d_readdata", n), rdat, last_rd);
      check($sformatf("rnd%0d_err", n), errs, (!in_win(a) || (rd && wr)) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1, 0, BASE + 32'(4 * i), 32'h0, 4'h0, rdat, waits, errs);
      check($sformatf("final_word%0d", i), rdat, mm[i]);
    end
    for (int i = 0; i < 4; i++) xfer(1, 0, 1, BASE + 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, rdat, waits, errs);
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, 0, BASE + 32'h100 + 32'(4 * i), 32'h0, 4'h0, rdat, waits, errs);
      chk_waits($sformatf("b2b%0d_waits", i), waits, 3);
      check($sformatf("b2b%0d_readdata", i), rdat, 32'hA000_0000 + 32'(i));
    end
`ifndef AVALON_BUS_RAM_RANDOM_WAIT_EN
    check("b2b_total_cycles", 32'(($time - t0) / 10), 16);
`endif
    xfer(1, 0, 1, BASE + 32'h20, 32'h1357_9BDF, 4'hF, rdat, waits, errs);
    drive(1, 0, 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    #4;
    check("rstmid_waitreq_c0", {31'b0, b3.waitrequest}, 1);
    @(posedge clk); #1;
    rst3 = 0;
    #1;
    check("rstmid_readdata", b3.readdata, 0);
    check("rstmid_err", {31'b0, b3.err}, 0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1;
    @(posedge clk); #1;
    xfer(1, 1, 0, BASE + 32'h20, 32'h0, 4'h0, rdat, waits, errs);
    check("rstmid_word_kept", rdat, 32'h1357_9BDF);
`ifdef AVALON_BUS_RAM_RANDOM_WAIT_EN
    seen = 4'b0;
    for (int i = 0; i < 64; i++) begin
      xfer(0, 1, 0, BASE, 32'h0, 4'h0, rdat, waits, errs);
      if (waits >= 1 && waits <= 4) seen[waits-1] = 1'b1;
      else begin
        n_chk++;
        $display("FAIL lfsr_wait_range: got %0d waits expected 1..4", waits);
      end
    end
    check("lfsr_wait_span", {28'b0, seen}, 32'hF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
